conv1d_pe_mc: RTL and testbench
===============================

Name: conv1d_pe_mc

Overview:
- Parametrised multi-filter 1-D convolution processing element; successor to the single-filter input/filter/MAC/output datapath.
- Loads an ifmap row and NUM_FILTERS filters into internal scratchpads over valid/ready streams.
- Computes every strided window against every filter, one MAC per cycle, and streams partial sums out.
- Sits between the global buffer (input side) and the psum/output FIFO.

Parameters:
- DATA_WIDTH, 8, signed ifmap/filter element width
- ACC_WIDTH, 24, signed accumulator and output width (>= 2*DATA_WIDTH)
- IF_DEPTH, 16, ifmap scratchpad entries (maximum row length)
- FILT_DEPTH, 32, filter scratchpad entries (NUM_FILTERS*K must fit)
- NUM_FILTERS, 2, filters applied per window
- MAX_K, 8, maximum filter size

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; starts a job when idle
- cfg_if_len  in  $clog2(IF_DEPTH+1)  ifmap length L
- cfg_k  in  $clog2(MAX_K+1)  filter size K
- cfg_stride  in  $clog2(IF_DEPTH+1)  stride S
- cfg_reuse_filt  in  1  when 1, skip filter load and reuse stored filters
- if_valid / if_ready / if_data  in/out/in  1/1/DATA_WIDTH  ifmap stream
- flt_valid / flt_ready / flt_data  in/out/in  1/1/DATA_WIDTH  filter stream, filter-major, tap-minor
- out_valid / out_ready  out/in  1/1  psum handshake
- out_data  out  ACC_WIDTH  psum
- out_filt  out  $clog2(NUM_FILTERS)  filter index of out_data
- busy  out  1  high when not IDLE
- done  out  1  one-cycle pulse on job completion
- cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset: FSM=IDLE; all counters 0; busy=0, done=0, cfg_err=0, out_valid=0, out_data=0, out_filt=0, if_ready=0, flt_ready=0. Scratchpad contents are not reset.
- Config and start:
  - cfg_* are sampled on the start cycle and ignored afterwards.
  - start while busy is ignored.
  - Reject (cfg_err pulse next cycle, stay IDLE) when: K==0, S==0, K>L, L>IF_DEPTH, K>MAX_K, NUM_FILTERS*K>FILT_DEPTH, or cfg_reuse_filt=1 while the stored-filter valid flag is 0.
- LOAD:
  - if_ready=1 until L words are accepted.
  - flt_ready=1 until NUM_FILTERS*K words are accepted; held 0 when reuse is set.
  - Both streams load concurrently; a word transfers on valid&&ready, one per stream per cycle.
  - Leave LOAD the cycle after the last word of both streams.
  - Stored-filter valid flag: set when a filter load completes; cleared by rst.
- COMPUTE:
  - Window positions p = 0, S, 2S, ... while p+K <= L.
  - Order: window-major, filter-minor.
  - Each (p,f) takes K cycles: acc = sum over t of if[p+t]*flt[f*K+t].
  - Arithmetic: signed DATA_WIDTH x DATA_WIDTH product, sign-extended to ACC_WIDTH; acc cleared at the start of each (p,f).
- EMIT:
  - out_valid=1 with out_data=acc and out_filt=f; held stable until out_ready.
  - The transfer cycle advances to the next (p,f) in COMPUTE.
  - Throughput: K+1 cycles per psum with out_ready held high.
- Job end: after the last psum transfers, enter DONE. done=1 for one cycle, then IDLE.
- Output count: (floor((L-K)/S)+1)*NUM_FILTERS.
- Boundaries:
  - K==L gives exactly one window.
  - Stride larger than the remaining length terminates cleanly; no partial windows.
  - out_ready low stalls EMIT indefinitely without corrupting state.
- rst mid-job: returns to IDLE the next edge; no done pulse; in-flight data is discarded.

Optional Feature:
- Macro: CONV1D_PE_SAT_EN.
- Defined: each accumulate step saturates to the signed ACC_WIDTH min/max; the saturation sticks for the rest of that psum.
- Undefined: accumulation wraps modulo 2^ACC_WIDTH.

Decomposition:
- Package conv_pe_pkg:
  - FSM state enum {IDLE, LOAD, COMPUTE, EMIT, DONE}
  - width helper constants derived from the parameters
  - saturating-add function used under the macro
- Sub-module pe_scratchpad (DEPTH, WIDTH): synchronous write, combinational read. Instantiated twice, once for ifmap and once for filters.

Test Plan:
- L=8, K=3, S=1, NF=2, if=1..8, flt0=(1,1,1), flt1=(1,0,-1) -> 12 psums: flt0 6,9,12,15,18,21; flt1 -2 each, interleaved f0,f1.
- L=9, K=3, S=2 -> 4 windows; p=8 is not computed; done pulses after 8 transfers.
- out_ready low for 5 cycles mid-job -> out_data/out_filt stable throughout; no psum lost or duplicated.
- Second job with cfg_reuse_filt=1 and new ifmap -> flt_ready stays 0; results match the first filters. Reuse requested after rst -> cfg_err pulse, busy stays 0.
- K=0 or K=10>L=8 -> cfg_err pulse, state IDLE; start during busy -> ignored.
- Operands 127*127 with K=8, ACC_WIDTH=16 -> wrapped value without the macro; 32767 with CONV1D_PE_SAT_EN.

Source files
------------

// File: rtl/conv_pe_pkg.sv
// conv_pe_pkg: shared definitions for the conv1d_pe_mc processing element.
//   - default parameter values for the PE and its scratchpads
//   - FSM state encoding (also exported on the PE debug port)
//   - width_of(): address/index width helper that never returns 0
//   - sat_add(): signed saturating add, used when CONV1D_PE_SAT_EN is defined
package conv_pe_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_ACC_WIDTH   = 24;
    localparam int DEF_IF_DEPTH    = 16;
    localparam int DEF_FILT_DEPTH  = 32;
    localparam int DEF_NUM_FILTERS = 2;
    localparam int DEF_MAX_K       = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_EMIT    = 3'd3,
        ST_DONE    = 3'd4
    } pe_state_e;

    // Width needed to index n entries; 1 for n <= 1 so ports never collapse.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // a + b clamped to the signed range of a w-bit number (w <= 63).
    // Operands are the w-bit values sign-extended to 64 bits.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [64:0] sum;
        logic signed [64:0] max_v;
        logic signed [64:0] min_v;
        sum   = 65'(a) + 65'(b);
        max_v = (65'sd1 <<< (w - 1)) - 65'sd1;
        min_v = -(65'sd1 <<< (w - 1));
        if (sum > max_v)
            sat_add = max_v[63:0];
        else if (sum < min_v)
            sat_add = min_v[63:0];
        else
            sat_add = sum[63:0];
    endfunction

endpackage

// File: rtl/pe_scratchpad.sv
// pe_scratchpad: small register-file scratchpad, synchronous write,
// combinational read. Contents are not reset.
// Ports:
//   clk      clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data (same-cycle)
module pe_scratchpad
    import conv_pe_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [width_of(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic [width_of(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]           o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/conv1d_pe_mc.sv
// conv1d_pe_mc: multi-filter 1-D convolution processing element.
// Loads an ifmap row (L words) and NUM_FILTERS filters of K taps into
// scratchpads, then for every window p = 0, S, 2S, ... (p+K <= L) and every
// filter f produces one psum = sum_t if[p+t] * flt[f*K+t], one MAC per cycle.
// Psums leave window-major, filter-minor; K+1 cycles per psum at full rate.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    one-cycle job start (ignored while busy)
//   cfg_if_len/k/stride      L, K, S sampled on the start cycle
//   cfg_reuse_filt           skip filter load, reuse stored filters
//   if_valid/ready/data      ifmap stream
//   flt_valid/ready/data     filter stream, filter-major, tap-minor
//   out_valid/ready/data     psum stream, out_filt = filter index
//   busy                     high whenever not IDLE
//   done                     one-cycle pulse at job completion
//   cfg_err                  one-cycle pulse when a start is rejected
//   dbg_state                current FSM state (conv_pe_pkg::pe_state_e)
//
// Handshake: a word moves on a cycle where valid && ready are both high at
// the rising edge; out_valid with out_data/out_filt stays stable until then.
//
// Build option CONV1D_PE_SAT_EN: accumulation saturates (sticky for the rest
// of the psum) instead of wrapping modulo 2^ACC_WIDTH. ACC_WIDTH <= 63.
module conv1d_pe_mc
    import conv_pe_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int IF_DEPTH    = DEF_IF_DEPTH,
    parameter int FILT_DEPTH  = DEF_FILT_DEPTH,
    parameter int NUM_FILTERS = DEF_NUM_FILTERS,
    parameter int MAX_K       = DEF_MAX_K
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [$clog2(IF_DEPTH+1)-1:0]    cfg_if_len,
    input  logic [$clog2(MAX_K+1)-1:0]       cfg_k,
    input  logic [$clog2(IF_DEPTH+1)-1:0]    cfg_stride,
    input  logic                             cfg_reuse_filt,
    input  logic                             if_valid,
    output logic                             if_ready,
    input  logic [DATA_WIDTH-1:0]            if_data,
    input  logic                             flt_valid,
    output logic                             flt_ready,
    input  logic [DATA_WIDTH-1:0]            flt_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ACC_WIDTH-1:0]             out_data,
    output logic [width_of(NUM_FILTERS)-1:0] out_filt,
    output logic                             busy,
    output logic                             done,
    output logic                             cfg_err,
    output logic [2:0]                       dbg_state
);

    localparam int LW  = $clog2(IF_DEPTH + 1);
    localparam int KW  = $clog2(MAX_K + 1);
    localparam int FIW = width_of(NUM_FILTERS);
    localparam int IAW = width_of(IF_DEPTH);
    localparam int FAW = width_of(FILT_DEPTH);
    localparam int FCW = $clog2(FILT_DEPTH + 1);

    pe_state_e               r_state;
    logic [LW-1:0]           r_len;
    logic [KW-1:0]           r_k;
    logic [LW-1:0]           r_stride;
    logic                    r_reuse;
    logic                    r_flt_valid;
    logic                    r_cfg_err;
    logic [LW-1:0]           r_if_cnt;
    logic [FCW-1:0]          r_flt_cnt;
    logic [FCW-1:0]          r_flt_total;
    logic [LW-1:0]           r_pos;
    logic [FIW-1:0]          r_filt;
    logic [KW-1:0]           r_tap;
    logic [FCW-1:0]          r_flt_base;
    logic signed [ACC_WIDTH-1:0] r_acc;

    logic                    w_cfg_bad;
    logic                    w_if_xfer;
    logic                    w_flt_xfer;
    logic                    w_if_done;
    logic                    w_flt_done;
    logic                    w_last_tap;
    logic                    w_last_filt;
    logic                    w_more_windows;
    logic [IAW-1:0]          w_if_raddr;
    logic [FAW-1:0]          w_flt_raddr;
    logic [DATA_WIDTH-1:0]   w_if_rdata;
    logic [DATA_WIDTH-1:0]   w_flt_rdata;
    logic signed [ACC_WIDTH-1:0] w_if_sx;
    logic signed [ACC_WIDTH-1:0] w_flt_sx;
    logic signed [ACC_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0] w_acc_next;

    assign w_cfg_bad = (cfg_k == '0) || (cfg_stride == '0) ||
                       (int'(cfg_k) > int'(cfg_if_len)) ||
                       (int'(cfg_if_len) > IF_DEPTH) ||
                       (int'(cfg_k) > MAX_K) ||
                       (NUM_FILTERS * int'(cfg_k) > FILT_DEPTH) ||
                       (cfg_reuse_filt && !r_flt_valid);

    assign if_ready   = (r_state == ST_LOAD) && (r_if_cnt < r_len);
    assign flt_ready  = (r_state == ST_LOAD) && !r_reuse && (r_flt_cnt < r_flt_total);
    assign w_if_xfer  = if_valid && if_ready;
    assign w_flt_xfer = flt_valid && flt_ready;

    // Each stream counts as finished if already complete or completing now,
    // so LOAD exits on the edge that accepts the last outstanding word.
    assign w_if_done  = (r_if_cnt == r_len) ||
                        (w_if_xfer && (r_if_cnt + LW'(1) == r_len));
    assign w_flt_done = r_reuse || (r_flt_cnt == r_flt_total) ||
                        (w_flt_xfer && (r_flt_cnt + FCW'(1) == r_flt_total));

    assign w_last_tap     = (r_tap == r_k - KW'(1));
    assign w_last_filt    = (r_filt == FIW'(NUM_FILTERS - 1));
    assign w_more_windows = (int'(r_pos) + int'(r_stride) + int'(r_k)) <= int'(r_len);

    // Indices are always below the scratchpad depth, so the low bits suffice.
    assign w_if_raddr  = r_pos[IAW-1:0] + IAW'(r_tap);
    assign w_flt_raddr = r_flt_base[FAW-1:0] + FAW'(r_tap);

    pe_scratchpad #(.DEPTH(IF_DEPTH), .WIDTH(DATA_WIDTH)) u_if_spad (
        .clk     (clk),
        .i_we    (w_if_xfer),
        .i_waddr (r_if_cnt[IAW-1:0]),
        .i_wdata (if_data),
        .i_raddr (w_if_raddr),
        .o_rdata (w_if_rdata)
    );

    pe_scratchpad #(.DEPTH(FILT_DEPTH), .WIDTH(DATA_WIDTH)) u_flt_spad (
        .clk     (clk),
        .i_we    (w_flt_xfer),
        .i_waddr (r_flt_cnt[FAW-1:0]),
        .i_wdata (flt_data),
        .i_raddr (w_flt_raddr),
        .o_rdata (w_flt_rdata)
    );

    // Operands are sign-extended first so the product is exact in ACC_WIDTH.
    assign w_if_sx  = ACC_WIDTH'($signed(w_if_rdata));
    assign w_flt_sx = ACC_WIDTH'($signed(w_flt_rdata));
    assign w_prod   = w_if_sx * w_flt_sx;

`ifdef CONV1D_PE_SAT_EN
    logic                        r_sat;
    logic signed [ACC_WIDTH-1:0] w_acc_wrap;
    logic signed [ACC_WIDTH-1:0] w_acc_sat;

    assign w_acc_wrap = r_acc + w_prod;
    assign w_acc_sat  = ACC_WIDTH'(sat_add(64'(r_acc), 64'(w_prod), ACC_WIDTH));
    // Once clamped, the psum holds its limit until the next psum starts.
    assign w_acc_next = r_sat ? r_acc : w_acc_sat;

    always_ff @(posedge clk) begin
        if (rst)
            r_sat <= 1'b0;
        else if (r_state == ST_COMPUTE) begin
            if (w_acc_sat != w_acc_wrap)
                r_sat <= 1'b1;
        end else if ((r_state != ST_EMIT) || out_ready)
            r_sat <= 1'b0;
    end
`else
    assign w_acc_next = r_acc + w_prod;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_k         <= '0;
            r_stride    <= '0;
            r_reuse     <= 1'b0;
            r_flt_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_if_cnt    <= '0;
            r_flt_cnt   <= '0;
            r_flt_total <= '0;
            r_pos       <= '0;
            r_filt      <= '0;
            r_tap       <= '0;
            r_flt_base  <= '0;
            r_acc       <= '0;
        end else begin
            r_cfg_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_cfg_bad)
                            r_cfg_err <= 1'b1;
                        else begin
                            r_len       <= cfg_if_len;
                            r_k         <= cfg_k;
                            r_stride    <= cfg_stride;
                            r_reuse     <= cfg_reuse_filt;
                            r_if_cnt    <= '0;
                            r_flt_cnt   <= '0;
                            r_flt_total <= FCW'(NUM_FILTERS * int'(cfg_k));
                            // A fresh filter load invalidates the old set until it completes.
                            if (!cfg_reuse_filt)
                                r_flt_valid <= 1'b0;
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_if_xfer)
                        r_if_cnt <= r_if_cnt + LW'(1);
                    if (w_flt_xfer) begin
                        r_flt_cnt <= r_flt_cnt + FCW'(1);
                        if (r_flt_cnt + FCW'(1) == r_flt_total)
                            r_flt_valid <= 1'b1;
                    end
                    if (w_if_done && w_flt_done) begin
                        r_pos      <= '0;
                        r_filt     <= '0;
                        r_tap      <= '0;
                        r_flt_base <= '0;
                        r_acc      <= '0;
                        r_state    <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    r_acc <= w_acc_next;
                    r_tap <= r_tap + KW'(1);
                    if (w_last_tap)
                        r_state <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        r_tap <= '0;
                        r_acc <= '0;
                        if (w_last_filt) begin
                            r_filt     <= '0;
                            r_flt_base <= '0;
                            if (w_more_windows) begin
                                r_pos   <= r_pos + r_stride;
                                r_state <= ST_COMPUTE;
                            end else
                                r_state <= ST_DONE;
                        end else begin
                            r_filt     <= r_filt + FIW'(1);
                            r_flt_base <= r_flt_base + FCW'(r_k);
                            r_state    <= ST_COMPUTE;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = (r_state == ST_EMIT);
    assign out_data  = r_acc;
    assign out_filt  = r_filt;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign cfg_err   = r_cfg_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_conv1d_pe_mc.sv
// tb_conv1d_pe_mc: directed bench for conv1d_pe_mc (ACC_WIDTH = 16 so the
// overflow case fits in a short job). Expected psums are hand-computed and
// queued per job; the collector pops them as psums transfer.
module tb_conv1d_pe_mc;

    localparam int DW  = 8;
    localparam int AW  = 16;
    localparam int IFD = 16;
    localparam int FD  = 32;
    localparam int NF  = 2;
    localparam int MK  = 8;
    localparam int LW  = $clog2(IFD + 1);
    localparam int KW  = $clog2(MK + 1);

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] cfg_if_len = '0;
    logic [KW-1:0] cfg_k = '0;
    logic [LW-1:0] cfg_stride = '0;
    logic          cfg_reuse_filt = 1'b0;
    logic          if_valid = 1'b0;
    logic          if_ready;
    logic [DW-1:0] if_data = '0;
    logic          flt_valid = 1'b0;
    logic          flt_ready;
    logic [DW-1:0] flt_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] out_data;
    logic [0:0]    out_filt;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    conv1d_pe_mc #(
        .DATA_WIDTH(DW), .ACC_WIDTH(AW), .IF_DEPTH(IFD),
        .FILT_DEPTH(FD), .NUM_FILTERS(NF), .MAX_K(MK)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_if_len(cfg_if_len), .cfg_k(cfg_k), .cfg_stride(cfg_stride),
        .cfg_reuse_filt(cfg_reuse_filt),
        .if_valid(if_valid), .if_ready(if_ready), .if_data(if_data),
        .flt_valid(flt_valid), .flt_ready(flt_ready), .flt_data(flt_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_filt(out_filt),
        .busy(busy), .done(done), .cfg_err(cfg_err), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int             n_checks = 0;
    int             n_errors = 0;
    logic [AW-1:0]  exp_q[$];
    logic [0:0]     exp_f_q[$];
    logic [DW-1:0]  if_vec[IFD];
    logic [DW-1:0]  flt_vec[FD];

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int v, input int f);
        exp_q.push_back(AW'(v));
        exp_f_q.push_back(1'(f));
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_job(input int l, input int k, input int s, input bit reuse);
        @(negedge clk);
        cfg_if_len     = LW'(l);
        cfg_k          = KW'(k);
        cfg_stride     = LW'(s);
        cfg_reuse_filt = reuse;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_if(input int n, input bit chk_flt_idle);
        int i;
        int cyc;
        i = 0;
        cyc = 0;
        while (i < n && cyc < 200) begin
            @(negedge clk);
            if_valid = ($urandom_range(0, 3) != 0);
            if_data  = if_vec[i];
            if (chk_flt_idle)
                check("flt_ready_reuse", 32'(flt_ready), 0);
            if (if_valid && if_ready)
                i++;
            cyc++;
        end
        @(negedge clk);
        if_valid = 1'b0;
        check("if_load_count", i, n);
    endtask

    task automatic drive_flt(input int n);
        int i;
        int cyc;
        i = 0;
        cyc = 0;
        while (i < n && cyc < 200) begin
            @(negedge clk);
            flt_valid = ($urandom_range(0, 2) != 0);
            flt_data  = flt_vec[i];
            if (flt_valid && flt_ready)
                i++;
            cyc++;
        end
        @(negedge clk);
        flt_valid = 1'b0;
        check("flt_load_count", i, n);
    endtask

    task automatic load(input int n_if, input int n_flt, input bit reuse);
        fork
            drive_if(n_if, reuse);
            drive_flt(n_flt);
        join
    endtask

    // Accepts psums until n_exp have transferred and done has pulsed.
    // out_ready is pulled low for stall_len cycles starting at stall_at.
    task automatic collect(input int n_exp, input int stall_at, input int stall_len);
        int got_n;
        int cyc;
        int done_n;
        got_n = 0;
        cyc = 0;
        done_n = 0;
        while ((got_n < n_exp || done_n == 0) && cyc < 1000) begin
            @(negedge clk);
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (done) begin
                done_n++;
                check("done_after_last", got_n, n_exp);
            end
            if (out_valid) begin
                if (exp_q.size() == 0)
                    check("extra_psum", 1, 0);
                else if (out_ready) begin
                    check("psum_data", $signed(out_data), $signed(exp_q[0]));
                    check("psum_filt", 32'(out_filt), 32'(exp_f_q[0]));
                    void'(exp_q.pop_front());
                    void'(exp_f_q.pop_front());
                    got_n++;
                end else begin
                    check("stall_data", $signed(out_data), $signed(exp_q[0]));
                    check("stall_filt", 32'(out_filt), 32'(exp_f_q[0]));
                end
            end
            cyc++;
        end
        out_ready = 1'b1;
        check("psum_count", got_n, n_exp);
        check("done_pulses", done_n, 1);
        @(negedge clk);
        check("done_cleared", 32'(done), 0);
        check("idle_after_done", 32'(busy), 0);
        exp_q.delete();
        exp_f_q.delete();
    endtask

    task automatic reject_case(input string tag, input int l, input int k,
                               input int s, input bit reuse);
        start_job(l, k, s, reuse);
        check({tag, "_cfg_err"}, 32'(cfg_err), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        @(negedge clk);
        check({tag, "_err_pulse"}, 32'(cfg_err), 0);
        check({tag, "_state"}, 32'(dbg_state), 0);
    endtask

    task automatic set_filters_a();
        flt_vec[0] = 8'sd1; flt_vec[1] = 8'sd1; flt_vec[2] = 8'sd1;
        flt_vec[3] = 8'sd1; flt_vec[4] = 8'sd0; flt_vec[5] = -8'sd1;
    endtask

    task automatic set_if_ramp(input int n);
        for (int i = 0; i < n; i++)
            if_vec[i] = DW'(i + 1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        check("watchdog", 0, 1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int done_seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_filt", 32'(out_filt), 0);
        check("rst_if_ready", 32'(if_ready), 0);
        check("rst_flt_ready", 32'(flt_ready), 0);
        check("rst_state", 32'(dbg_state), 0);

        // Job A: L=8 K=3 S=1, if=1..8, f0=(1,1,1), f1=(1,0,-1)
        set_if_ramp(8);
        set_filters_a();
        push_exp(6, 0);  push_exp(-2, 1);
        push_exp(9, 0);  push_exp(-2, 1);
        push_exp(12, 0); push_exp(-2, 1);
        push_exp(15, 0); push_exp(-2, 1);
        push_exp(18, 0); push_exp(-2, 1);
        push_exp(21, 0); push_exp(-2, 1);
        start_job(8, 3, 1, 1'b0);
        check("a_busy", 32'(busy), 1);
        check("a_state_load", 32'(dbg_state), 1);
        load(8, 6, 1'b0);
        collect(12, 1000, 0);

        // Job C: reuse filters A, if=(10,-20,30,-40,50), L=5 K=3 S=1
        if_vec[0] = 8'sd10; if_vec[1] = -8'sd20; if_vec[2] = 8'sd30;
        if_vec[3] = -8'sd40; if_vec[4] = 8'sd50;
        push_exp(20, 0);  push_exp(-20, 1);
        push_exp(-30, 0); push_exp(20, 1);
        push_exp(40, 0);  push_exp(-20, 1);
        start_job(5, 3, 1, 1'b1);
        check("c_flt_ready", 32'(flt_ready), 0);
        check("c_if_ready", 32'(if_ready), 1);
        load(5, 0, 1'b1);
        collect(6, 1000, 0);

        // Job D: reuse, K==L=3, stride 5 larger than the row: one window
        if_vec[0] = 8'sd4; if_vec[1] = 8'sd5; if_vec[2] = 8'sd6;
        push_exp(15, 0); push_exp(-2, 1);
        start_job(3, 3, 5, 1'b1);
        load(3, 0, 1'b1);
        collect(2, 1000, 0);

        // Job B: L=9 K=3 S=2, if=1..9, f0=(2,-1,3), f1=(0,1,0); stall 5 cycles
        set_if_ramp(9);
        flt_vec[0] = 8'sd2; flt_vec[1] = -8'sd1; flt_vec[2] = 8'sd3;
        flt_vec[3] = 8'sd0; flt_vec[4] = 8'sd1;  flt_vec[5] = 8'sd0;
        push_exp(9, 0);  push_exp(2, 1);
        push_exp(17, 0); push_exp(4, 1);
        push_exp(25, 0); push_exp(6, 1);
        push_exp(33, 0); push_exp(8, 1);
        start_job(9, 3, 2, 1'b0);
        load(9, 6, 1'b0);
        collect(8, 6, 5);

        // Reset in the middle of a job: idle next edge, no done pulse
        set_if_ramp(8);
        set_filters_a();
        start_job(8, 3, 1, 1'b0);
        load(8, 6, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_state", 32'(dbg_state), 0);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy)
                done_seen++;
        end
        check("midrst_quiet", done_seen, 0);

        // Rejected starts
        reject_case("rej_reuse", 8, 3, 1, 1'b1);
        reject_case("rej_k0", 8, 0, 1, 1'b0);
        reject_case("rej_k_gt_l", 8, 10, 1, 1'b0);
        reject_case("rej_s0", 8, 3, 0, 1'b0);

        // Job E: 127*127 over K=8, plus a start while busy (must be ignored)
        for (int i = 0; i < 8; i++) begin
            if_vec[i]      = 8'sd127;
            flt_vec[i]     = 8'sd127;
            flt_vec[i + 8] = -8'sd127;
        end
`ifdef CONV1D_PE_SAT_EN
        push_exp(32767, 0); push_exp(-32768, 1);
`else
        push_exp(-2040, 0); push_exp(2040, 1);
`endif
        start_job(8, 8, 1, 1'b0);
        cfg_k = KW'(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_err", 32'(cfg_err), 0);
        check("busy_start_state", 32'(dbg_state), 1);
        load(8, 16, 1'b0);
        collect(2, 1000, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
